// File: rtl/balls_collision_scheduler.sv
// Serialises ball-pair collision requests into one speed calculator: round-robin grant,
// per-pair frame cooldown, and an abort if the calculator never reports done.
module balls_collision_scheduler #(
  parameter int NUM_BALLS       = 3,
  parameter int ID_W            = 4,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   startOfFrame,
  input  logic [NUM_BALLS*(NUM_BALLS-1)/2-1:0]   pair_hit,
  input  logic                                   calc_done,
  output logic                                   calc_start,
  output logic [1:0][ID_W-1:0]                   Balls_col_ID,
  output logic [NUM_BALLS-1:0]                   balls_collide,
  output logic                                   busy,
  output logic [7:0]                             served_cnt,
  output logic                                   timeout_err
);

  localparam int NUM_PAIRS = NUM_BALLS*(NUM_BALLS-1)/2;
  localparam int PIDX_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CD_W      = $clog2(COOLDOWN_FRAMES+1);
  localparam int TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                          state, next_state;
  logic [NUM_PAIRS-1:0]            pending;
  logic [NUM_PAIRS-1:0][CD_W-1:0]  cooldown;
  logic [NUM_PAIRS-1:0]            cd_zero;
  logic [PIDX_W-1:0]               rr_ptr, gnt, gnt_sel, sel_hi, sel_lo;
  logic                            found_hi, found_lo, any_pend;
  logic [TO_W-1:0]                 wait_cnt;
  logic                            finish, timed_out;
  logic [ID_W-1:0]                 lo_id, hi_id;
  logic [NUM_BALLS-1:0]            col_mask;
  logic                            nx_calc_start, nx_busy;
  logic [1:0][ID_W-1:0]            nx_ids;
  logic [NUM_BALLS-1:0]            nx_collide;

  assign any_pend  = |pending;
  assign timed_out = (state == S_WAIT) && !calc_done && (wait_cnt == TO_W'(TIMEOUT_CYC-1));
  assign finish    = (state == S_WAIT) && (calc_done || wait_cnt == TO_W'(TIMEOUT_CYC-1));

  always_comb begin
    for (int p = 0; p < NUM_PAIRS; p++) cd_zero[p] = (cooldown[p] == '0);
  end

  // Round-robin: first pending at or above rr_ptr, otherwise wrap to the lowest pending.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (pending[p] && !found_lo) begin
        found_lo = 1'b1;
        sel_lo   = PIDX_W'(p);
      end
      if (pending[p] && !found_hi && PIDX_W'(p) >= rr_ptr) begin
        found_hi = 1'b1;
        sel_hi   = PIDX_W'(p);
      end
    end
    gnt_sel = found_hi ? sel_hi : sel_lo;
  end

  // Pair index -> (lower, higher) ball IDs; only legal pairs exist in the table.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    col_mask = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      for (int j = i + 1; j < NUM_BALLS; j++) begin
        if (gnt_sel == PIDX_W'(i*NUM_BALLS - i*(i+1)/2 + (j-i-1))) begin
          lo_id       = ID_W'(i);
          hi_id       = ID_W'(j);
          col_mask    = '0;
          col_mask[i] = 1'b1;
          col_mask[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_pend) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (finish) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    nx_calc_start = (state == S_IDLE) && any_pend;
    nx_busy       = (next_state != S_IDLE);
    nx_ids        = Balls_col_ID;
    nx_collide    = balls_collide;
    if (state == S_IDLE && any_pend) begin
      nx_ids     = {hi_id, lo_id};
      nx_collide = col_mask;
    end else if (next_state == S_IDLE) begin
      nx_ids     = '0;
      nx_collide = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      cooldown      <= '0;
      rr_ptr        <= '0;
      gnt           <= '0;
      wait_cnt      <= '0;
      calc_start    <= 1'b0;
      busy          <= 1'b0;
      Balls_col_ID  <= '0;
      balls_collide <= '0;
      served_cnt    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      // Service clear/load beats a same-cycle hit or frame decrement.
      for (int p = 0; p < NUM_PAIRS; p++) begin
        if (finish && gnt == PIDX_W'(p)) begin
          pending[p]  <= 1'b0;
          cooldown[p] <= CD_W'(COOLDOWN_FRAMES);
        end else begin
          pending[p] <= pending[p] | (pair_hit[p] & cd_zero[p]);
          if (startOfFrame && !cd_zero[p]) cooldown[p] <= cooldown[p] - CD_W'(1);
        end
      end
      if (state == S_IDLE && any_pend) gnt <= gnt_sel;
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      if (finish) begin
        rr_ptr <= (gnt == PIDX_W'(NUM_PAIRS-1)) ? '0 : gnt + PIDX_W'(1);
        if (calc_done) served_cnt <= served_cnt + 8'd1;
        if (timed_out) timeout_err <= 1'b1;
      end
      calc_start    <= nx_calc_start;
      busy          <= nx_busy;
      Balls_col_ID  <= nx_ids;
      balls_collide <= nx_collide;
    end
  end

endmodule

// File: tb/tb_balls_collision_scheduler.sv
// Randomised and directed bench for balls_collision_scheduler against a transaction-level model.
module tb_balls_collision_scheduler;
  localparam int NB = 3, NP = 3, IDW = 4, CF = 4, TO = 64;

  logic            clk = 1'b0, reset = 1'b1, sof = 1'b0, done = 1'b0;
  logic [NP-1:0]   hit = '0;
  logic            calc_start, busy, timeout_err;
  logic [1:0][IDW-1:0] ids;
  logic [NB-1:0]   collide;
  logic [7:0]      served;

  balls_collision_scheduler #(.NUM_BALLS(NB), .ID_W(IDW), .COOLDOWN_FRAMES(CF), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pair_hit(hit), .calc_done(done),
    .calc_start(calc_start), .Balls_col_ID(ids), .balls_collide(collide), .busy(busy),
    .served_cnt(served), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a job is the pair currently owned by the calculator, age = cycles since grant.
  int pl[NP], ph[NP];
  bit m_pend[NP];
  int m_cd[NP];
  int m_rr, m_job = -1, m_age, m_served;
  bit m_terr, m_valid = 0;

  initial begin
    int k;
    k = 0;
    for (int i = 0; i < NB; i++)
      for (int j = i + 1; j < NB; j++) begin
        pl[k] = i; ph[k] = j; k++;
      end
  end

  always @(posedge clk) begin : mdl
    bit op[NP];
    int ocd[NP];
    int oj, oa, g, p;
    bit fin;
    if (reset) begin
      for (int i = 0; i < NP; i++) begin m_pend[i] = 0; m_cd[i] = 0; end
      m_rr = 0; m_job = -1; m_age = 0; m_served = 0; m_terr = 0; m_valid = 1;
    end else begin
      op = m_pend; ocd = m_cd; oj = m_job; oa = m_age;
      fin = (oj >= 0) && (oa >= 1) && (done || oa == TO);
      for (int i = 0; i < NP; i++) begin
        m_pend[i] = op[i] | (hit[i] && ocd[i] == 0);
        if (sof && ocd[i] > 0) m_cd[i] = ocd[i] - 1;
      end
      if (fin) begin
        m_pend[oj] = 0;
        m_cd[oj]   = CF;
        m_rr       = (oj + 1) % NP;
        if (done) m_served = (m_served + 1) % 256;
        else      m_terr = 1;
        m_job = -1;
      end else if (oj >= 0) begin
        m_age = oa + 1;
      end else begin
        g = -1;
        for (int k = 0; k < NP; k++) begin
          p = (m_rr + k) % NP;
          if (g < 0 && op[p]) g = p;
        end
        if (g >= 0) begin m_job = g; m_age = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("calc_start", 32'(calc_start), 32'(m_job >= 0 && m_age == 0));
      chk("busy", 32'(busy), 32'(m_job >= 0));
      chk("ids", 32'(ids), (m_job >= 0) ? 32'(ph[m_job] * 16 + pl[m_job]) : 32'd0);
      chk("collide", 32'(collide), (m_job >= 0) ? 32'((1 << pl[m_job]) | (1 << ph[m_job])) : 32'd0);
      chk("served_cnt", 32'(served), 32'(m_served));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (calc_start === 1'b1) ok = 1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1; hit = '0; sof = 0; done = 0;
    tick(); tick();
    reset = 0;
  endtask

  // After a service: three frames keep the pair idle, the fourth lets it back in.
  task automatic cooldown_frames(input string nm);
    for (int f = 0; f < 4; f++) begin
      repeat (3) tick();
      chk({nm, "_idle"}, 32'(busy), 32'd0);
      sof = 1; tick(); sof = 0;
    end
    wait_start({nm, "_reissue"});
  endtask

  initial begin
    logic [31:0] order [3];
    int starts, cyc;
    order[0] = 32'h10; order[1] = 32'h20; order[2] = 32'h21;

    reset = 1;
    tick(); tick();
    chk("rst_calc_start", 32'(calc_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ids", 32'(ids), 32'd0);
    chk("rst_served", 32'(served), 32'd0);
    reset = 0;

    // Single hit on pair (0,2): latency, IDs, service, cooldown.
    hit = 3'b010;
    tick(); chk("t1_lat1", 32'(calc_start), 32'd0);
    tick(); chk("t1_start", 32'(calc_start), 32'd1);
    chk("t1_ids", 32'(ids), 32'h20);
    chk("t1_collide", 32'(collide), 32'h5);
    tick(); tick(); tick();
    chk("t1_ids_held", 32'(ids), 32'h20);
    done = 1; tick(); done = 0;
    chk("t1_served", 32'(served), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    cooldown_frames("t1_cool");
    tick(); done = 1; tick(); done = 0;

    // Round robin across all three pairs.
    do_reset();
    hit = 3'b111;
    for (int s = 0; s < 3; s++) begin
      wait_start("t2_start");
      chk("t2_order", 32'(ids), order[s]);
      tick(); done = 1; tick(); done = 0;
    end
    hit = '0;
    repeat (3) tick();

    // Service and frame pulse on the same cycle: full cooldown reload.
    do_reset();
    hit = 3'b001;
    wait_start("t3_start");
    tick(); done = 1; sof = 1; tick(); done = 0; sof = 0;
    cooldown_frames("t3_cool");
    tick(); done = 1; tick(); done = 0;
    hit = '0;

    // Timeout on pair (0,2) then pair (1,2) granted.
    do_reset();
    hit = 3'b010;
    wait_start("t4_start");
    hit = 3'b110;
    repeat (64) tick();
    chk("t4_pre_to", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_to", 32'(timeout_err), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_served", 32'(served), 32'd0);
    wait_start("t4_next");
    chk("t4_next_ids", 32'(ids), 32'h21);
    hit = '0;
    tick(); done = 1; tick(); done = 0;

    // Reset while waiting, then a stray done.
    do_reset();
    hit = 3'b001;
    wait_start("t5_start");
    tick(); tick();
    reset = 1; tick(); reset = 0; hit = '0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ids", 32'(ids), 32'd0);
    chk("t5_collide", 32'(collide), 32'd0);
    done = 1; tick(); done = 0;
    chk("t5_served", 32'(served), 32'd0);
    tick();
    chk("t5_no_issue", 32'(busy), 32'd0);

    // Random traffic with done-less stretches that force timeouts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) hit = NP'($urandom);
      sof   = ($urandom_range(0, 7) == 0);
      done  = (c % 600 < 480) ? ($urandom_range(0, 2) == 0) : 1'b0;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 0; done = 0; sof = 0; hit = '0;

    // 256 services wrap the counter.
    do_reset();
    hit = 3'b111; sof = 1;
    starts = 0; cyc = 0;
    while (starts < 256 && cyc < 4000) begin
      tick(); cyc++;
      done = busy && !calc_start;
      if (calc_start === 1'b1) starts++;
    end
    chk("t6_starts", 32'(starts), 32'd256);
    tick(); done = busy && !calc_start;
    tick(); done = 0; hit = '0; sof = 0;
    chk("t6_wrap", 32'(served), 32'd0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
